// File: rtl/csr_commit_unit_pkg.sv
// Shared types and FSM encodings for the CSR commit sequencer.
// Holds the CSR command set, privilege levels and the effective-write rule.
package csr_commit_unit_pkg;

    typedef enum logic [1:0] {
        CSR_RW = 2'd0,
        CSR_RS = 2'd1,
        CSR_RC = 2'd2,
        CSR_RD = 2'd3
    } csr_cmd_t;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_lvl_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_EXC   = 3'd4;

    // Set/clear with a zero operand are pure reads and must not trip read-only checks.
    function automatic logic csr_eff_write(input csr_cmd_t op, input logic wdata_nz);
        logic result;
        result = 1'b0;
        case (op)
            CSR_RW:         result = 1'b1;
            CSR_RS, CSR_RC: result = wdata_nz;
            default:        result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_access_check.sv
// Combinational CSR legality check: privilege level and read-only space.
// Takes only address bits [11:8], which carry the access encoding.
module csr_access_check
    import csr_commit_unit_pkg::*;
(
    input  logic [3:0] addr_hi_i,
    input  logic [1:0] priv_i,
    input  logic       we_i,
    output logic       illegal_o
);

    priv_lvl_t w_priv;
    logic      w_priv_fault;
    logic      w_ro_fault;

    assign w_priv       = priv_lvl_t'(priv_i);
    assign w_priv_fault = addr_hi_i[1:0] > w_priv;
    assign w_ro_fault   = we_i && (addr_hi_i[3:2] == 2'b11);
    assign illegal_o    = w_priv_fault || w_ro_fault;

endmodule

// File: rtl/csr_commit_unit.sv
// Commit-side CSR read-modify-write sequencer with privilege/read-only checks.
// Returns the old CSR value and acknowledges the address buffer on completion.
module csr_commit_unit
    import csr_commit_unit_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned CSR_ADDR_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  commit_valid_i,
    output logic                  commit_ready_o,
    input  logic [1:0]            commit_op_i,
    input  logic [CSR_ADDR_W-1:0] commit_addr_i,
    input  logic [XLEN-1:0]       commit_wdata_i,
    input  logic [1:0]            priv_lvl_i,
    output logic                  commit_ack_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  rdata_valid_o,
    output logic                  ex_valid_o,
    output logic                  csr_req_o,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_addr_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    input  logic [XLEN-1:0]       csr_rdata_i
);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    csr_cmd_t              r_op;
    logic [CSR_ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_we;
    logic [XLEN-1:0]       r_rdata;
    logic [XLEN-1:0]       r_new;
    logic [XLEN-1:0]       r_rdata_hold;

    csr_cmd_t              w_op_in;
    logic                  w_we_in;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_issue_read;
    logic [XLEN-1:0]       w_new;

    assign w_op_in = csr_cmd_t'(commit_op_i);
    assign w_we_in = csr_eff_write(w_op_in, |commit_wdata_i);

    csr_access_check u_access_check (
        .addr_hi_i (commit_addr_i[CSR_ADDR_W-1 -: 4]),
        .priv_i    (priv_lvl_i),
        .we_i      (w_we_in),
        .illegal_o (w_illegal)
    );

    assign w_accept     = (r_state == ST_IDLE) && commit_valid_i && !flush_i;
    assign w_issue_read = w_accept && !w_illegal;

    always_comb begin
        w_new = csr_rdata_i;
        case (r_op)
            CSR_RW:  w_new = r_wdata;
            CSR_RS:  w_new = csr_rdata_i | r_wdata;
            CSR_RC:  w_new = csr_rdata_i & ~r_wdata;
            default: w_new = csr_rdata_i;
        endcase
    end

    // WRITE and DONE ignore flush: the instruction is committed once the write issues.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? ST_EXC : ST_READ;
                end
            end
            ST_READ: begin
                if (flush_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_we ? ST_WRITE : ST_DONE;
                end
            end
            ST_WRITE: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_EXC:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_op         <= CSR_RW;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_rdata      <= '0;
            r_new        <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= w_op_in;
                r_addr  <= commit_addr_i;
                r_wdata <= commit_wdata_i;
                r_we    <= w_we_in;
            end
            if (r_state == ST_READ) begin
                r_rdata <= csr_rdata_i;
                r_new   <= w_new;
            end
            if (r_state == ST_DONE) begin
                r_rdata_hold <= r_rdata;
            end
        end
    end

    assign commit_ready_o = (r_state == ST_IDLE);
    assign csr_req_o      = w_issue_read || (r_state == ST_WRITE);
    assign csr_we_o       = (r_state == ST_WRITE);
    assign csr_addr_o     = (r_state == ST_WRITE) ? r_addr :
                            (w_issue_read ? commit_addr_i : '0);
    assign csr_wdata_o    = (r_state == ST_WRITE) ? r_new : '0;
    assign commit_ack_o   = (r_state == ST_DONE);
    assign rdata_valid_o  = (r_state == ST_DONE);
    assign ex_valid_o     = (r_state == ST_EXC) && !flush_i;
    assign rdata_o        = (r_state == ST_DONE) ? r_rdata : r_rdata_hold;

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed self-checking bench for csr_commit_unit.
// ctl packs {ready, req, we, ack, rdata_valid, ex} for per-cycle comparison.
module tb_csr_commit_unit;
    import csr_commit_unit_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 12;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            valid;
    logic            ready;
    logic [1:0]      op;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      priv;
    logic            ack;
    logic [XLEN-1:0] rdata;
    logic            rvalid;
    logic            exv;
    logic            req;
    logic            we;
    logic [AW-1:0]   caddr;
    logic [XLEN-1:0] cwdata;
    logic [XLEN-1:0] crdata;
    logic [5:0]      ctl;

    int checks = 0;
    int errors = 0;

    csr_commit_unit #(.XLEN(XLEN), .CSR_ADDR_W(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .commit_valid_i (valid),
        .commit_ready_o (ready),
        .commit_op_i    (op),
        .commit_addr_i  (addr),
        .commit_wdata_i (wdata),
        .priv_lvl_i     (priv),
        .commit_ack_o   (ack),
        .rdata_o        (rdata),
        .rdata_valid_o  (rvalid),
        .ex_valid_o     (exv),
        .csr_req_o      (req),
        .csr_we_o       (we),
        .csr_addr_o     (caddr),
        .csr_wdata_o    (cwdata),
        .csr_rdata_i    (crdata)
    );

    assign ctl = {ready, req, we, ack, rvalid, exv};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input csr_cmd_t c, input logic [AW-1:0] a,
                            input logic [XLEN-1:0] d, input priv_lvl_t p,
                            input logic [XLEN-1:0] rd);
        valid  = 1'b1;
        op     = c;
        addr   = a;
        wdata  = d;
        priv   = p;
        crdata = rd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 6'b100000); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (caddr !== '0 || cwdata !== '0) begin errors++; $display("FAIL reset_bus got %h/%h exp 0/0", caddr, cwdata); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_rw();
        start_op(CSR_RW, 12'h340, 64'hDEAD, PRIV_M, 64'h1234);
        @(negedge clk);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL rw_accept ctl got %b exp %b", ctl, 6'b110000); end
        checks++; if (caddr !== 12'h340) begin errors++; $display("FAIL rw_read_addr got %h exp 340", caddr); end
        next_cycle(); valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rw_read ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL rw_write ctl got %b exp %b", ctl, 6'b011000); end
        checks++; if (cwdata !== 64'hDEAD || caddr !== 12'h340) begin errors++; $display("FAIL rw_write_data got %h@%h exp dead@340", cwdata, caddr); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL rw_done ctl got %b exp %b", ctl, 6'b000110); end
        checks++; if (rdata !== 64'h1234) begin errors++; $display("FAIL rw_rdata got %h exp 1234", rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rw_idle ctl got %b exp %b", ctl, 6'b100000); end
        checks++; if (rdata !== 64'h1234) begin errors++; $display("FAIL rw_rdata_hold got %h exp 1234", rdata); end
        next_cycle();
    endtask

    task automatic test_rs_zero();
        start_op(CSR_RS, 12'h300, 64'h0, PRIV_M, 64'h55);
        @(negedge clk);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL rs0_accept ctl got %b exp %b", ctl, 6'b110000); end
        next_cycle(); valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL rs0_read ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110) begin errors++; $display("FAIL rs0_done ctl got %b exp %b", ctl, 6'b000110); end
        checks++; if (rdata !== 64'h55) begin errors++; $display("FAIL rs0_rdata got %h exp 55", rdata); end
        next_cycle();
    endtask

    task automatic test_rc();
        start_op(CSR_RC, 12'h300, 64'h0F, PRIV_M, 64'hFF);
        @(negedge clk);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL rc_accept ctl got %b exp %b", ctl, 6'b110000); end
        next_cycle(); valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL rc_write ctl got %b exp %b", ctl, 6'b011000); end
        checks++; if (cwdata !== 64'hF0) begin errors++; $display("FAIL rc_wdata got %h exp f0", cwdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110 || rdata !== 64'hFF) begin errors++; $display("FAIL rc_done ctl/rdata got %b/%h exp 000110/ff", ctl, rdata); end
        next_cycle();
    endtask

    task automatic test_illegal(input csr_cmd_t c, input logic [AW-1:0] a,
                                input logic [XLEN-1:0] d, input priv_lvl_t p);
        start_op(c, a, d, p, 64'h99);
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL ill_accept_%h ctl got %b exp %b", a, ctl, 6'b100000); end
        next_cycle(); valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000001) begin errors++; $display("FAIL ill_exc_%h ctl got %b exp %b", a, ctl, 6'b000001); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL ill_idle_%h ctl got %b exp %b", a, ctl, 6'b100000); end
        next_cycle();
    endtask

    task automatic test_ro_read();
        start_op(CSR_RS, 12'hF14, 64'h0, PRIV_M, 64'h2A);
        @(negedge clk);
        checks++; if (ctl !== 6'b110000 || caddr !== 12'hF14) begin errors++; $display("FAIL ro_read_accept got %b@%h exp 110000@f14", ctl, caddr); end
        next_cycle(); valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110 || rdata !== 64'h2A) begin errors++; $display("FAIL ro_read_done got %b/%h exp 000110/2a", ctl, rdata); end
        next_cycle();
    endtask

    task automatic test_flush();
        // flush in IDLE blocks acceptance
        start_op(CSR_RW, 12'h340, 64'h1, PRIV_M, 64'h3);
        flush = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL flush_idle ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle(); valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL flush_idle_next ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        // flush in READ aborts
        start_op(CSR_RW, 12'h340, 64'h1, PRIV_M, 64'h3);
        next_cycle(); valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL flush_read ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle(); flush = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL flush_read_idle ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL flush_read_noack ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle();
        // flush in WRITE and DONE is ignored
        start_op(CSR_RW, 12'h340, 64'hABC, PRIV_M, 64'h77);
        next_cycle(); valid = 1'b0;
        next_cycle(); flush = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b011000 || cwdata !== 64'hABC) begin errors++; $display("FAIL flush_write got %b/%h exp 011000/abc", ctl, cwdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110 || rdata !== 64'h77) begin errors++; $display("FAIL flush_done got %b/%h exp 000110/77", ctl, rdata); end
        next_cycle(); flush = 1'b0;
        // flush in EXC suppresses the exception pulse
        start_op(CSR_RW, 12'hF14, 64'h1, PRIV_M, 64'h0);
        next_cycle(); valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL flush_exc ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle(); flush = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL flush_exc_idle ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        start_op(CSR_RD, 12'h300, 64'h0, PRIV_M, 64'h77);
        @(negedge clk);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL b2b_acc1 ctl got %b exp %b", ctl, 6'b110000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL b2b_read1 ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110 || rdata !== 64'h77) begin errors++; $display("FAIL b2b_done1 got %b/%h exp 000110/77", ctl, rdata); end
        next_cycle(); crdata = 64'h88;
        @(negedge clk);
        checks++; if (ctl !== 6'b110000) begin errors++; $display("FAIL b2b_acc2 ctl got %b exp %b", ctl, 6'b110000); end
        next_cycle(); valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL b2b_read2 ctl got %b exp %b", ctl, 6'b000000); end
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b000110 || rdata !== 64'h88) begin errors++; $display("FAIL b2b_done2 got %b/%h exp 000110/88", ctl, rdata); end
        next_cycle();
    endtask

    task automatic test_reset_in_write();
        start_op(CSR_RW, 12'h340, 64'h5A5A, PRIV_M, 64'h11);
        next_cycle(); valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b011000) begin errors++; $display("FAIL rstw_write ctl got %b exp %b", ctl, 6'b011000); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rstw_ctl got %b exp %b", ctl, 6'b100000); end
        checks++; if (cwdata !== '0 || caddr !== '0 || rdata !== '0) begin errors++; $display("FAIL rstw_bus got %h/%h/%h exp 0/0/0", cwdata, caddr, rdata); end
        @(negedge clk); rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rstw_noack ctl got %b exp %b", ctl, 6'b100000); end
        next_cycle();
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        op     = 2'd0;
        addr   = '0;
        wdata  = '0;
        priv   = 2'd3;
        crdata = '0;
        test_reset();
        test_rw();
        test_rs_zero();
        test_rc();
        test_illegal(CSR_RW, 12'hF14, 64'h1, PRIV_M);
        test_illegal(CSR_RD, 12'h300, 64'h0, PRIV_U);
        test_illegal(CSR_RC, 12'hF14, 64'h4, PRIV_M);
        test_ro_read();
        test_flush();
        test_back_to_back();
        test_reset_in_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_commit_unit.md
Name: csr_commit_unit

Overview:
Commit-side sequencer between the commit stage and the CSR register file. It executes the architectural read-modify-write of a committed CSR instruction. The CSR address comes from the single-entry CSR address buffer, and the operand comes from the scoreboard result. It returns the old CSR value for integer-register writeback and pulses the commit acknowledge that frees the address buffer. It also detects privilege and read-only violations and reports them as exceptions instead of performing the access.

Parameters:
XLEN, 64, data width of operands and CSR values
CSR_ADDR_W, 12, CSR address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset (see Behaviour)
flush_i  in  1  pipeline flush
commit_valid_i  in  1  committed CSR instruction presented
commit_ready_o  out  1  unit idle, can accept
commit_op_i  in  2  csr_cmd_t: CSR_RW=0, CSR_RS=1, CSR_RC=2, CSR_RD=3
commit_addr_i  in  CSR_ADDR_W  CSR address from address buffer
commit_wdata_i  in  XLEN  rs1/zimm operand
priv_lvl_i  in  2  current privilege (U=0, S=1, M=3)
commit_ack_o  out  1  one-cycle pulse, drives address-buffer commit input
rdata_o  out  XLEN  old CSR value for rd writeback
rdata_valid_o  out  1  rdata_o valid (same cycle as commit_ack_o)
ex_valid_o  out  1  one-cycle illegal-instruction exception pulse
csr_req_o  out  1  CSR file access strobe
csr_we_o  out  1  write (1) / read (0)
csr_addr_o  out  CSR_ADDR_W  CSR file address
csr_wdata_o  out  XLEN  CSR file write data
csr_rdata_i  in  XLEN  CSR file read data, valid exactly 1 cycle after a read strobe

Behaviour:
- Reset: rst_ni is asynchronous and active-low; clk_i is the clock. On reset, state=IDLE and every output and internal register is 0, except commit_ready_o=1.
- States: IDLE, READ, WRITE, DONE, EXC.
- IDLE: commit_ready_o=1. When commit_valid_i=1, latch the op, address and wdata, then apply the legality check combinationally on the inputs.
- Illegal access, either condition below:
  - addr[9:8] > priv_lvl_i;
  - an effective write with addr[11:10]==2'b11.
- Illegal access -> EXC. No CSR access is issued.
- Legal access -> drive csr_req_o=1, csr_we_o=0, csr_addr_o=addr in this same cycle -> READ.
- Effective write:
  - CSR_RW always writes.
  - CSR_RS and CSR_RC write only when wdata!=0.
  - CSR_RD never writes.
- READ: capture csr_rdata_i into rdata_q and compute new value, XLEN-wide with no truncation:
  - RW: new = wdata;
  - RS: new = rdata | wdata;
  - RC: new = rdata & ~wdata.
- READ transitions: effective write -> WRITE; otherwise -> DONE.
- WRITE: csr_req_o=1, csr_we_o=1, csr_wdata_o=new, csr_addr_o=addr -> DONE.
- DONE: commit_ack_o=1, rdata_valid_o=1, rdata_o=rdata_q -> IDLE.
- EXC: ex_valid_o=1, commit_ack_o=0 (the address buffer is cleared by the ensuing flush) -> IDLE.
- Latency from accept cycle T: ack at T+2 with no write, T+3 with a write; exception at T+1.
- commit_ready_o=0 in every state except IDLE. A new commit is accepted at the earliest in the cycle after DONE or EXC. Back-to-back throughput is 1 per 3 or 4 cycles.
- Flush:
  - IDLE: flush_i blocks acceptance that cycle.
  - READ or EXC: abort to IDLE, no ack, no exception pulse, no write.
  - WRITE or DONE: flush_i is ignored; the write completes and the ack is still issued, because the instruction is architecturally committed once the write is issued.
- Outside their active states, csr_req_o, csr_we_o, commit_ack_o, rdata_valid_o and ex_valid_o are 0. rdata_o holds its last value.
- Reset asserted mid-operation returns to IDLE immediately, with no pending write and no ack.

Decomposition:
- Shared package: csr_cmd_t enum, and the priv_lvl_t encoding if not already present.
- The legality check is natural as a small combinational sub-module, csr_access_check: inputs addr, priv, write flag; output illegal.
- The FSM and the datapath stay in csr_commit_unit.

Test Plan:
1. CSR_RW, addr 0x340, wdata 0xDEAD, priv M, csr_rdata_i 0x1234 -> read strobe at T, write of 0xDEAD at T+2, ack and rdata_o=0x1234 at T+3.
2. CSR_RS, addr 0x300, wdata 0, priv M -> read only, no csr_we_o at any point, ack at T+2 with old value.
3. CSR_RC, addr 0x300, rdata 0xFF, wdata 0x0F -> write 0xF0 at T+2, ack at T+3.
4. CSR_RW to 0xF14 (read-only), and separately CSR_RD of 0x300 at priv U -> ex_valid_o at T+1, no csr_req_o, no ack. CSR_RS with wdata 0 to 0xF14 -> legal, ack at T+2.
5. flush_i in READ -> no write, no ack, IDLE next cycle. flush_i in WRITE -> write and ack still occur.
6. Back-to-back commit_valid_i held high -> second op accepted only in the cycle after DONE. Reset asserted in WRITE -> all outputs 0 and commit_ready_o=1 immediately.
